// File: rtl/lt_pattern_gen.sv
// Level-translator bank driver: ramps the per-bank chip enables and drives a test pattern onto the data pins.
// Define LT_ENABLE_SEQ_EN for the staggered per-tick enable ramp; without it the banks switch all at once.
module lt_pattern_gen #(
  parameter int BANKS      = 8,
  parameter int BANK_WIDTH = 8,
  parameter int DIV_WIDTH  = 24
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        run,
  input  logic [1:0]                  mode,
  input  logic [DIV_WIDTH-1:0]        step_div,
  input  logic [BANK_WIDTH-1:0]       static_pat,
  output logic [BANKS-1:0]            enable_bit,
  output logic [BANKS*BANK_WIDTH-1:0] data_bit,
  output logic                        busy,
  output logic                        ready,
  output logic                        tick
);

  localparam int N = BANKS * BANK_WIDTH;

  typedef enum logic [1:0] {IDLE, UP, RUN, DOWN} state_t;

  state_t               state, state_n;
  logic [DIV_WIDTH-1:0] cnt, cnt_n, div_q, div_n;
  logic [1:0]           mode_q, mode_n;
  logic [BANKS-1:0]     en_n;
  logic [N-1:0]         data_n;
  logic                 tick_now;

  function automatic logic [N-1:0] replicate(input logic [BANK_WIDTH-1:0] sp);
    return {BANKS{sp}};
  endfunction

  function automatic logic [N-1:0] init_pat(input logic [1:0] m,
                                            input logic [BANK_WIDTH-1:0] sp);
    logic [N-1:0] p;
    p = '0;
    case (m)
      2'd0: p = replicate(sp);
      2'd1: p[0] = 1'b1;
      2'd2: p = '0;
      default: for (int i = 0; i < N; i++) p[i] = (i % 2 == 0);
    endcase
    return p;
  endfunction

  function automatic logic [N-1:0] next_pat(input logic [1:0] m, input logic [N-1:0] cur);
    logic [N-1:0] p;
    case (m)
      2'd1:    p = {cur[N-2:0], cur[N-1]};
      2'd2:    p = cur + N'(1);
      2'd3:    p = ~cur;
      default: p = cur;
    endcase
    return p;
  endfunction

  // The prescaler runs in every state except IDLE and keeps counting across UP/RUN/DOWN.
  assign tick_now = (state != IDLE) && (cnt == div_q);

  always_comb begin
    state_n = state;
    cnt_n   = tick_now ? '0 : cnt + DIV_WIDTH'(1);
    div_n   = div_q;
    mode_n  = mode_q;
    en_n    = enable_bit;
    data_n  = data_bit;
    case (state)
      IDLE: begin
        cnt_n  = '0;
        en_n   = '0;
        data_n = '0;
        if (run) begin
          state_n = UP;
          div_n   = step_div;
          mode_n  = mode;
        end
      end
      UP: begin
        data_n = '0;
`ifdef LT_ENABLE_SEQ_EN
        if (!run) begin
          state_n = DOWN;
        end else if (tick_now) begin
          en_n = {enable_bit[BANKS-2:0], 1'b1};
          if (&en_n) begin
            state_n = RUN;
            data_n  = init_pat(mode_q, static_pat);
          end
        end
`else
        if (!run) begin
          state_n = DOWN;
        end else begin
          en_n    = '1;
          state_n = RUN;
          data_n  = init_pat(mode_q, static_pat);
        end
`endif
      end
      RUN: begin
        // Shutdown wins over a tick landing in the same cycle.
        if (!run) begin
          state_n = DOWN;
          data_n  = '0;
        end else if (mode_q == 2'd0) begin
          data_n = replicate(static_pat);
        end else if (tick_now) begin
          data_n = next_pat(mode_q, data_bit);
        end
      end
      default: begin
        data_n = '0;
`ifdef LT_ENABLE_SEQ_EN
        if (enable_bit == '0) state_n = IDLE;
        else if (tick_now) en_n = enable_bit >> 1;
`else
        en_n    = '0;
        state_n = IDLE;
`endif
      end
    endcase
  end

  // Single register stage: every output is a flop fed from the next-state logic.
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      cnt        <= '0;
      div_q      <= '0;
      mode_q     <= '0;
      enable_bit <= '0;
      data_bit   <= '0;
      busy       <= 1'b0;
      ready      <= 1'b0;
      tick       <= 1'b0;
    end else begin
      state      <= state_n;
      cnt        <= cnt_n;
      div_q      <= div_n;
      mode_q     <= mode_n;
      enable_bit <= en_n;
      data_bit   <= data_n;
      busy       <= (state_n != IDLE);
      ready      <= (state_n == RUN);
      tick       <= (state_n != IDLE) && (cnt_n == div_n);
    end
  end

endmodule

// File: tb/tb_lt_pattern_gen.sv
// Bench for lt_pattern_gen (BANKS=2, BANK_WIDTH=4): expected outputs derived from cycle counts since run rose.
module tb_lt_pattern_gen;

  localparam int BANKS = 2;
  localparam int BW    = 4;
  localparam int DW    = 8;
  localparam int N     = BANKS * BW;
`ifdef LT_ENABLE_SEQ_EN
  localparam bit SEQ = 1'b1;
`else
  localparam bit SEQ = 1'b0;
`endif

  logic             clk = 1'b0;
  logic             rst, run;
  logic [1:0]       mode;
  logic [DW-1:0]    step_div;
  logic [BW-1:0]    static_pat;
  logic [BANKS-1:0] enable_bit;
  logic [N-1:0]     data_bit;
  logic             busy, ready, tick;

  int checks = 0;
  int errors = 0;

  lt_pattern_gen #(.BANKS(BANKS), .BANK_WIDTH(BW), .DIV_WIDTH(DW)) dut (
    .clk(clk), .rst(rst), .run(run), .mode(mode), .step_div(step_div),
    .static_pat(static_pat), .enable_bit(enable_bit), .data_bit(data_bit),
    .busy(busy), .ready(ready), .tick(tick)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Ticks seen in cycles 1..k-1, cycle 1 being the first cycle after run was sampled high.
  function automatic int tc(input int k, input int d);
    return (k - 1) / (d + 1);
  endfunction

  function automatic bit tk(input int k, input int d);
    return ((k - 1) % (d + 1)) == d;
  endfunction

  function automatic logic [BANKS-1:0] ones(input int n);
    logic [BANKS-1:0] r;
    r = '0;
    for (int i = 0; i < BANKS; i++) if (i < n) r[i] = 1'b1;
    return r;
  endfunction

  function automatic logic [N-1:0] pat(input int m, input int p, input logic [BW-1:0] sp);
    case (m)
      0:       return {sp, sp};
      1:       return N'(1 << (p % N));
      2:       return N'(p % (1 << N));
      default: return (p % 2 == 0) ? 8'h55 : 8'hAA;
    endcase
  endfunction

  task automatic check_all(input string tag, input logic [BANKS-1:0] en, input logic [N-1:0] dat,
                           input bit b, input bit r, input bit t);
    chk({tag, ".enable"}, 64'(enable_bit), 64'(en));
    chk({tag, ".data"},   64'(data_bit),   64'(dat));
    chk({tag, ".busy"},   64'(busy),       64'(b));
    chk({tag, ".ready"},  64'(ready),      64'(r));
    chk({tag, ".tick"},   64'(tick),       64'(t));
  endtask

  task automatic session(input int m, input int d, input logic [BW-1:0] sp0,
                         input logic [BW-1:0] sp1, input int run_len, input bit reraise);
    int kr, kend, tb_cyc, last_busy, nt;
    logic [BW-1:0] sp;
    logic [BANKS-1:0] en_e;
    sp = sp0;
    mode = 2'(m);
    step_div = DW'(d);
    static_pat = sp;
    run = 1'b1;
    step();
    kr = SEQ ? BANKS * (d + 1) + 1 : 2;
    kend = kr + run_len;
    for (int k = 1; k <= kend; k++) begin
      if (k < kr) en_e = SEQ ? ones(tc(k, d)) : '0;
      else        en_e = '1;
      check_all($sformatf("up_run m%0d d%0d k%0d", m, d, k), en_e,
                (k < kr) ? '0 : pat(m, tc(k, d) - tc(kr, d), sp), 1'b1, k >= kr, tk(k, d));
      if (k > 1 && k < kend) begin
        mode = 2'($urandom);
        step_div = DW'($urandom);
      end
      if (k == kr + 1) sp = sp1;
      static_pat = sp;
      if (k == kend) begin
        mode = 2'(m);
        step_div = DW'(d);
        run = 1'b0;
      end
      step();
    end
    // Shutdown: locate the tick that clears the last bank.
    nt = 0;
    tb_cyc = kend + 1;
    for (int c = kend + 1; c < kend + 4 * BANKS * (d + 1) + 4; c++) begin
      if (tk(c, d)) nt++;
      if (nt == BANKS) begin
        tb_cyc = c;
        break;
      end
    end
    last_busy = SEQ ? tb_cyc + 1 : kend + 1;
    for (int c = kend + 1; c <= last_busy + 1; c++) begin
      if (SEQ) en_e = ones(BANKS - (tc(c, d) - tc(kend + 1, d)));
      else     en_e = (c == kend + 1) ? '1 : '0;
      check_all($sformatf("down m%0d d%0d c%0d", m, d, c), en_e, '0,
                c <= last_busy, 1'b0, (c <= last_busy) ? tk(c, d) : 1'b0);
      if (reraise) run = 1'b1;
      step();
    end
    if (reraise) begin
      check_all("reraise_up", '0, '0, 1'b1, 1'b0, d == 0);
      repeat (d + 2) step();
      rst = 1'b1;
      run = 1'b0;
      step();
      check_all("rst_mid_up", '0, '0, 1'b0, 1'b0, 1'b0);
      rst = 1'b0;
      step();
      check_all("after_rst_up", '0, '0, 1'b0, 1'b0, 1'b0);
    end
  endtask

  initial begin
    rst = 1'b1;
    run = 1'b0;
    mode = 2'd0;
    step_div = '0;
    static_pat = '0;
    step();
    step();
    check_all("reset", '0, '0, 1'b0, 1'b0, 1'b0);
    rst = 1'b0;
    step();
    check_all("idle", '0, '0, 1'b0, 1'b0, 1'b0);

    session(1, 2, 4'h0, 4'h0, 30, 1'b0);
    session(2, 0, 4'h0, 4'h0, 260, 1'b0);
    session(3, 1, 4'h0, 4'h0, 10, 1'b0);
    session(0, 1, 4'hA, 4'h3, 6, 1'b0);
    session(1, 2, 4'h0, 4'h0, 12, 1'b1);
    for (int i = 0; i < 6; i++)
      session(int'($urandom_range(0, 3)), int'($urandom_range(0, 3)), 4'($urandom),
              4'($urandom), int'($urandom_range(3, 40)), 1'($urandom));

    mode = 2'd2;
    step_div = '0;
    run = 1'b1;
    repeat (10) step();
    chk("pre_rst_run.ready", 64'(ready), 64'(1));
    rst = 1'b1;
    step();
    check_all("rst_mid_run", '0, '0, 1'b0, 1'b0, 1'b0);
    rst = 1'b0;
    run = 1'b0;
    step();
    check_all("after_rst_run", '0, '0, 1'b0, 1'b0, 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/lt_pattern_gen.md
# lt_pattern_gen

Parametrised driver for the level-translator bank array. It sequences the per-bank chip enables up and down, and drives a configurable test pattern onto all data pins while the banks are up. It sits between mojo_top control logic (switches/LEDs/host commands) and the enable_bit/data_bit pins. It replaces the fixed "all enabled, two static bits" hookup.

## Interface
- BANKS, 8, number of translator chips (one enable each), ≥2
- BANK_WIDTH, 8, data pins per chip; N = BANKS*BANK_WIDTH
- DIV_WIDTH, 24, width of step divider
- clk  in  1  50 MHz system clock
- rst  in  1  synchronous, active-high reset
- run  in  1  level; 1 = bring banks up and run pattern, 0 = shut down
- mode  in  2  pattern select, sampled on leaving IDLE: 0 static, 1 walking-one, 2 counter, 3 alternate
- step_div  in  DIV_WIDTH  tick period minus one, sampled on leaving IDLE
- static_pat  in  BANK_WIDTH  byte replicated across banks in mode 0 (live, not sampled)
- enable_bit  out  BANKS  chip enables, active high
- data_bit  out  N  translator data pins
- busy  out  1  state != IDLE
- ready  out  1  state == RUN
- tick  out  1  one-cycle pulse per prescaler tick

## Operation
- Clock and reset: one clock, clk; reset rst is synchronous and active-high.
- Prescaler: cnt cleared on leaving IDLE. tick=1 when cnt==div_q, then cnt←0, else cnt+1. step_div=0 gives a tick every cycle. No ticks in IDLE.
- States: IDLE, UP, RUN, DOWN.
- IDLE: enable_bit=0, data_bit=0. If run=1, latch mode_q/div_q and go to UP.
- UP: data_bit=0. Each tick, enable_bit←{enable_bit[BANKS-2:0],1'b1}. On the tick that makes enable_bit all-ones, go to RUN and load the initial pattern. If run=0, go to DOWN.
- RUN: data_bit holds the pattern and advances on each tick. If run=0, go to DOWN; the run=0 check has priority over a coincident tick.
- DOWN: data_bit←0 on entry cycle. Each tick, enable_bit←enable_bit>>1, so the highest bank drops first. On the cycle enable_bit==0, go to IDLE. run is ignored until IDLE.
- Patterns (N bits, all wrap):
  - 0 static: {BANKS{static_pat}}; a static_pat change shows on the next cycle.
  - 1 walking-one: initial bit 0 set; rotate left; bit N-1 wraps to bit 0.
  - 2 counter: initial 0; +1 mod 2^N; all-ones wraps to 0.
  - 3 alternate: initial ...0101 (bit 0 = 1); bitwise invert per tick.
- mode and step_div changes outside IDLE have no effect.

## Timing
- All outputs are registered. Reset values: enable_bit=0, data_bit=0, busy=0, ready=0, tick=0, state IDLE, cnt=0.
- run high in IDLE at cycle t: busy=1 at t+1. First tick at t+1+div_q.
- UP to RUN: BANKS ticks; ready=1 and the initial pattern appear in the cycle after the last enable tick.
- run low in RUN at cycle t: ready=0 and data_bit=0 at t+1. Banks drop one per tick. busy=0 in the cycle after enable_bit reaches 0.
- rst mid-operation: all outputs return to reset values on the next edge, with no ramp-down.

## Configuration
- LT_ENABLE_SEQ_EN defined: staggered per-tick bank enable and disable, as described above.
- LT_ENABLE_SEQ_EN undefined:
  - UP lasts one cycle and sets enable_bit to all-ones at once, then goes to RUN.
  - DOWN lasts one cycle and clears enable_bit at once.
  - Prescaler, patterns and handshakes are unchanged.

## Test plan
- BANKS=2, BANK_WIDTH=4, step_div=2, mode=1, macro defined; raise run → enable_bit 01 then 11 at 3-cycle spacing; data_bit 0x01, 0x02, …, 0x80, 0x01 (wrap).
- mode=2, step_div=0, N=8: data_bit 0x00…0xFF then 0x00; tick high every cycle in RUN.
- mode=3: data_bit alternates 0x55/0xAA per tick; mode=0 with static_pat=0xA gives 0xAA, and changing it to 0x3 gives 0x33 next cycle.
- Drop run in RUN → data_bit=0 next cycle, enable_bit 11→01→00 one per tick, busy falls after; re-raising run during DOWN is ignored until IDLE.
- Assert rst mid-UP and mid-RUN → all outputs 0 next cycle. Rebuild without LT_ENABLE_SEQ_EN → enable_bit jumps 00→11 and 11→00 in single cycles.
